sync_frame_tx: RTL

- Serial frame transmitter. Emits SYNC_WORD MSB-first, then payload bytes MSB-first, one bit per clk, on a single-bit line.
- Pairs with the team's bit-serial Mealy sync detector (pattern 0-1-0-1-0-1-0-1), which sits at the far end of the line.
- Upstream supplies bytes through a valid/ready handshake, with a last marker that closes the frame.

---
 rtl/sync_frame_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: SYNC_WORD then payload bytes, MSB-first, one bit per clk.
// Define SYNC_FRAME_TX_PARITY_EN to append an even-parity bit after every payload byte.
module sync_frame_tx #(
    parameter logic [7:0]  SYNC_WORD  = 8'h55,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic       dout,
    output logic       dout_en,
    output logic       busy,
    output logic       frame_done
);
    // state | meaning
    // IDLE  | line idle, waiting for the first byte of a frame
    // SYNC  | shifting out SYNC_WORD
    // DATA  | shifting out the held payload byte (plus parity when enabled)
    // WAIT  | underrun: frame still open, no byte available yet
    // GAP   | inter-frame idle line, GAP_CYCLES long
    typedef enum logic [2:0] {IDLE, SYNC, DATA, WAIT, GAP} state_t;

`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam logic [3:0] BYTE_LAST = 4'd8;
`else
    localparam logic [3:0] BYTE_LAST = 4'd7;
`endif
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] bit_cnt, bit_cnt_nx;
    logic [3:0] gap_cnt, gap_cnt_nx;
    logic [7:0] hold;
    logic       hold_last;
    logic       dout_nx, dout_en_nx, done_nx;
    logic       xfer;

    assign xfer = din_valid && din_ready;
    assign busy = (state != IDLE);

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        gap_cnt_nx = gap_cnt;
        din_ready  = 1'b0;
        dout_nx    = 1'b1;
        dout_en_nx = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    state_nx   = SYNC;
                    bit_cnt_nx = '0;
                end
            end
            SYNC: begin
                dout_en_nx = 1'b1;
                dout_nx    = SYNC_WORD[3'd7 - bit_cnt[2:0]];
                if (bit_cnt == 4'd7) begin
                    state_nx   = DATA;
                    bit_cnt_nx = '0;
                end else begin
                    bit_cnt_nx = bit_cnt + 4'd1;
                end
            end
            DATA: begin
                dout_en_nx = 1'b1;
                dout_nx    = hold[3'd7 - bit_cnt[2:0]];
`ifdef SYNC_FRAME_TX_PARITY_EN
                if (bit_cnt == BYTE_LAST) dout_nx = ^hold;
`endif
                if (bit_cnt == BYTE_LAST) begin
                    // Accepting here lets the next byte follow with no bubble.
                    din_ready  = !hold_last;
                    bit_cnt_nx = '0;
                    if (hold_last) begin
                        state_nx   = GAP;
                        gap_cnt_nx = GAP_LOAD;
                    end else if (!din_valid) begin
                        state_nx = WAIT;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + 4'd1;
                end
            end
            WAIT: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    state_nx   = DATA;
                    bit_cnt_nx = '0;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) state_nx = IDLE;
                else                 gap_cnt_nx = gap_cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign done_nx = (state == DATA) && (state_nx == GAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            hold       <= '0;
            hold_last  <= 1'b0;
            dout       <= 1'b1;
            dout_en    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            gap_cnt    <= gap_cnt_nx;
            dout       <= dout_nx;
            dout_en    <= dout_en_nx;
            frame_done <= done_nx;
            if (xfer) begin
                hold      <= din;
                hold_last <= din_last;
            end
        end
    end
endmodule
